// File: rtl/uart_tx_mmio_if.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_mmio_if
// Brief    : Bus-side bundle between the RV32I data-bus decoder and the
//            memory-mapped UART transmitter.
// Signals  : cs_uart_n  - chip select, active low
//            uart_write - 1 = store, 0 = load (qualified by cs_uart_n)
//            uart_addr  - byte offset, [3:2] selects the register
//            uart_wdata - store data
//            uart_rdata - registered load data
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_tx_mmio_if;
    logic        cs_uart_n;
    logic        uart_write;
    logic [3:0]  uart_addr;
    logic [31:0] uart_wdata;
    logic [31:0] uart_rdata;

    // Bus master side (CPU / decoder)
    modport master (
        output cs_uart_n,
        output uart_write,
        output uart_addr,
        output uart_wdata,
        input  uart_rdata
    );

    // Peripheral side (UART transmitter)
    modport slave (
        input  cs_uart_n,
        input  uart_write,
        input  uart_addr,
        input  uart_wdata,
        output uart_rdata
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_mmio.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_mmio
// Brief    : Memory-mapped 8N1 UART transmitter with an N-entry TX FIFO.
//            CPU stores to TXDATA are queued; an FSM pops bytes and shifts
//            them out LSB first on uart_txd.
// Ports    : clk       - system clock
//            reset     - synchronous, active-high reset
//            bus       - uart_tx_mmio_if.slave (chip select, write strobe,
//                        address, write data, registered read data)
//            uart_txd  - serial output, idle high, driven from a flop
// Registers: 0x0 TXDATA  W: push wdata[7:0]          R: 0
//            0x4 STATUS  R: {24'b0, count[3:0], overflow, busy, empty, full}
//                        W: wdata[3]=1 clears overflow
//            0x8 BAUDDIV R/W bits [15:0], writes below 2 stored as 2
//            0xC         R: 0, writes ignored
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_mmio #(
    parameter int CLOCK_FREQ  = 125_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DEFAULT_DIV = CLOCK_FREQ / BAUD_RATE,
    parameter int FIFO_DEPTH  = 8
) (
    input  wire logic     clk,
    input  wire logic     reset,
    uart_tx_mmio_if.slave bus,
    output logic          uart_txd
);

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = FIFO_DEPTH[c_CNT_W-1:0];
    localparam logic [15:0]        c_DIV_ONE   = 16'd1;
    localparam logic [15:0]        c_DIV_MIN   = 16'd2;
    localparam logic [15:0]        c_RST_DIV   = (DEFAULT_DIV < 2) ? 16'd2
                                                                  : DEFAULT_DIV[15:0];

    localparam logic [1:0] c_REG_TXDATA  = 2'd0;
    localparam logic [1:0] c_REG_STATUS  = 2'd1;
    localparam logic [1:0] c_REG_BAUDDIV = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic [15:0]        r_div;
    logic [31:0]        r_rdata;

    state_t             r_state;
    logic [7:0]         r_shift;     // byte being sent, shifted right per bit
    logic [2:0]         r_bit_idx;
    logic [15:0]        r_bit_cnt;   // counts latched divisor-1 down to 0
    logic [15:0]        r_cur_div;   // divisor latched at frame start
    logic               r_txd;

    //--------------------------------------------------------------------------
    // Bus decode
    //--------------------------------------------------------------------------
    logic        w_access;
    logic        w_wr;
    logic        w_rd;
    logic [1:0]  w_sel;
    logic        w_push_req;
    logic        w_push;
    logic        w_pop;
    logic        w_empty;
    logic        w_full;
    logic        w_busy;
    logic        w_ovf_set;
    logic        w_ovf_clr;
    logic        w_div_wr;
    logic        w_bit_done;
    logic [3:0]  w_count4;
    logic [31:0] w_status;
    logic        w_unused;

    assign w_access   = ~bus.cs_uart_n;
    assign w_wr       = w_access &  bus.uart_write;
    assign w_rd       = w_access & ~bus.uart_write;
    assign w_sel      = bus.uart_addr[3:2];

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_DEPTH_CNT);
    assign w_busy     = (r_state != S_IDLE);

    // The FSM only looks at the registered count, so a byte pushed into an
    // empty FIFO is first seen by the FSM one cycle later.
    assign w_pop      = (r_state == S_IDLE) && !w_empty;

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle; otherwise the byte is lost and overflow is flagged.
    assign w_push_req = w_wr && (w_sel == c_REG_TXDATA);
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && !w_push;
    assign w_ovf_clr  = w_wr && (w_sel == c_REG_STATUS) && bus.uart_wdata[3];
    assign w_div_wr   = w_wr && (w_sel == c_REG_BAUDDIV);

    assign w_bit_done = (r_bit_cnt == '0);

    // STATUS carries a 4-bit count field regardless of FIFO depth.
    generate
        if (c_CNT_W >= 4) begin : g_cnt_trunc
            assign w_count4 = r_count[3:0];
        end else begin : g_cnt_pad
            assign w_count4 = {{(4 - c_CNT_W){1'b0}}, r_count};
        end
    endgenerate

    assign w_status = {24'b0, w_count4, r_overflow, w_busy, w_empty, w_full};

    // Address bits [1:0] and the upper store-data bits carry no meaning here.
    assign w_unused = &{1'b0, bus.uart_addr[1:0], bus.uart_wdata[31:16]};

    //--------------------------------------------------------------------------
    // FIFO storage (no reset needed: contents are only read when count > 0)
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.uart_wdata[7:0];
        end
    end

    //--------------------------------------------------------------------------
    // FIFO pointers and occupancy
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Control registers and registered read data
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_div      <= c_RST_DIV;
            r_rdata    <= '0;
        end else begin
            // A new overflow takes priority over a clear in the same cycle.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end

            if (w_div_wr) begin
                r_div <= (bus.uart_wdata[15:0] < c_DIV_MIN) ? c_DIV_MIN
                                                            : bus.uart_wdata[15:0];
            end

            if (w_rd) begin
                case (w_sel)
                    c_REG_STATUS:  r_rdata <= w_status;
                    c_REG_BAUDDIV: r_rdata <= {16'b0, r_div};
                    default:       r_rdata <= '0;
                endcase
            end
        end
    end

    assign bus.uart_rdata = r_rdata;

    //--------------------------------------------------------------------------
    // Transmit FSM: START, 8 DATA bits LSB first, STOP, each lasting exactly
    // r_cur_div clocks. Returning to IDLE after STOP costs one clock before
    // the next start bit, giving a single idle clock between frames.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_bit_cnt <= '0;
            r_cur_div <= c_RST_DIV;
            r_txd     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_shift   <= r_mem[r_rptr];
                        r_cur_div <= r_div;
                        r_bit_cnt <= r_div - c_DIV_ONE;
                        r_txd     <= 1'b0;
                        r_state   <= S_START;
                    end
                end

                S_START: begin
                    if (w_bit_done) begin
                        r_bit_idx <= 3'd0;
                        r_bit_cnt <= r_cur_div - c_DIV_ONE;
                        r_txd     <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - c_DIV_ONE;
                    end
                end

                S_DATA: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= r_cur_div - c_DIV_ONE;
                        if (r_bit_idx == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            // Next bit is already sitting at [1] before the shift.
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_txd     <= r_shift[1];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - c_DIV_ONE;
                    end
                end

                S_STOP: begin
                    r_txd <= 1'b1;
                    if (w_bit_done) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - c_DIV_ONE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign uart_txd = r_txd;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_tx_mmio
// Brief    : Self-checking bench for uart_tx_mmio. A transaction-level model
//            (byte queue, frame list with start cycle and divisor) predicts
//            read data and the serial line every cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_mmio;

    localparam int CLOCK_FREQ = 125_000_000;
    localparam int BAUD_RATE  = 115_200;
    localparam int DEF_DIV    = CLOCK_FREQ / BAUD_RATE;
    localparam int DEPTH      = 8;

    logic clk = 1'b0;
    logic reset;
    logic txd;

    uart_tx_mmio_if bus ();

    uart_tx_mmio #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .DEFAULT_DIV(DEF_DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .uart_txd(txd)
    );

    always #5 clk = ~clk;

    //--------------------------------------------------------------------------
    // Reference model state
    //--------------------------------------------------------------------------
    typedef struct {
        int         start;   // first cycle the start bit is on the line
        int         div;     // clocks per bit for this frame
        logic [7:0] data;
    } frame_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [7:0]  m_q[$];
    frame_t      m_frames[$];
    int          m_free_at;    // first cycle the transmitter can take a byte
    int          m_busy_from;
    int          m_div;
    bit          m_ovf;
    logic [31:0] m_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic exp_txd(input int t);
        foreach (m_frames[i]) begin
            int s = m_frames[i].start;
            int d = m_frames[i].div;
            if (t >= s && t < s + 10 * d) begin
                int b = (t - s) / d;
                if (b == 0) return 1'b0;
                if (b == 9) return 1'b1;
                return m_frames[i].data[b-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] status_now();
        int n = m_q.size();
        bit busy = (cyc >= m_busy_from) && (cyc < m_free_at);
        return {24'b0, 4'(n), m_ovf, busy, (n == 0), (n == DEPTH)};
    endfunction

    // One bus cycle: drive, predict the effect of the coming edge, then check.
    task automatic step(input bit cs, input bit wr, input logic [3:0] addr, input logic [31:0] wd);
        bit         pop;
        int         size_pre;
        logic [1:0] sel;
        bus.cs_uart_n  = ~cs;
        bus.uart_write = wr;
        bus.uart_addr  = addr;
        bus.uart_wdata = wd;
        reset          = 1'b0;
        sel            = addr[3:2];
        size_pre       = m_q.size();
        pop            = (cyc >= m_free_at) && (size_pre != 0);

        if (cs && !wr) begin
            case (sel)
                2'd1:    m_rdata = status_now();
                2'd2:    m_rdata = 32'(m_div);
                default: m_rdata = 32'h0;
            endcase
        end

        if (pop) begin
            m_frames.push_back('{start: cyc + 1, div: m_div, data: m_q.pop_front()});
            m_busy_from = cyc + 1;
            m_free_at   = cyc + 1 + 10 * m_div;
        end

        if (cs && wr && sel == 2'd0) begin
            if (size_pre < DEPTH || pop) m_q.push_back(wd[7:0]);
            else                         m_ovf = 1'b1;
        end
        if (cs && wr && sel == 2'd1 && wd[3]) m_ovf = 1'b0;
        if (cs && wr && sel == 2'd2) m_div = (wd[15:0] < 16'd2) ? 2 : int'(wd[15:0]);

        @(posedge clk);
        #1;
        cyc++;
        chk("rdata", bus.uart_rdata, m_rdata);
        chk("txd", 32'(txd), 32'(exp_txd(cyc)));
        while (m_frames.size() != 0 && m_frames[0].start + 10 * m_frames[0].div <= cyc)
            void'(m_frames.pop_front());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            bus.cs_uart_n  = 1'b1;
            bus.uart_write = 1'b0;
            bus.uart_addr  = 4'h0;
            bus.uart_wdata = 32'h0;
            reset          = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
            m_q.delete();
            m_frames.delete();
            m_ovf       = 1'b0;
            m_div       = DEF_DIV;
            m_rdata     = 32'h0;
            m_free_at   = cyc;
            m_busy_from = cyc;
            chk("rst_txd", 32'(txd), 32'h1);
            chk("rst_rdata", bus.uart_rdata, 32'h0);
        end
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (m_q.size() != 0 || cyc < m_free_at); i++) idle(1);
        idle(2);
    endtask

    //--------------------------------------------------------------------------
    // Stimulus
    //--------------------------------------------------------------------------
    initial begin
        int          s;
        int          r;
        logic [31:0] wd;
        logic [1:0]  lo;

        do_reset(3);

        // Reset values
        step(1'b1, 1'b0, 4'h4, 32'h0);
        chk("rst_status", bus.uart_rdata, 32'h2);
        step(1'b1, 1'b0, 4'h8, 32'h0);
        chk("rst_bauddiv", bus.uart_rdata, 32'(DEF_DIV));
        idle(1);

        // Single frame 0x55 at 4 clocks/bit, STATUS polled throughout
        step(1'b1, 1'b1, 4'h8, 32'd4);
        step(1'b1, 1'b1, 4'h0, 32'h55);
        for (int i = 0; i < 44; i++) step(1'b1, 1'b0, 4'h4, 32'h0);
        chk("frame_done_status", bus.uart_rdata, 32'h2);

        // Burst of 10 bytes: 9 accepted, last dropped
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 4'h0, 32'(i));
        step(1'b1, 1'b0, 4'h4, 32'h0);
        chk("burst_status", bus.uart_rdata, 32'h8D);
        step(1'b1, 1'b1, 4'h4, 32'h8);
        step(1'b1, 1'b0, 4'h4, 32'h0);
        chk("ovf_cleared", bus.uart_rdata, 32'h85);

        // Push exactly on the pop cycle while full
        for (int i = 0; i < 200 && cyc < m_free_at; i++) idle(1);
        step(1'b1, 1'b1, 4'h0, 32'hEE);
        step(1'b1, 1'b0, 4'h4, 32'h0);
        chk("pushpop_status", bus.uart_rdata, 32'h85);
        drain();

        // Divisor clamp and mid-frame divisor change
        step(1'b1, 1'b1, 4'h8, 32'h0);
        step(1'b1, 1'b0, 4'h8, 32'h0);
        chk("div_clamp", bus.uart_rdata, 32'h2);
        step(1'b1, 1'b1, 4'h0, 32'hA3);
        idle(4);
        step(1'b1, 1'b1, 4'h8, 32'd6);
        step(1'b1, 1'b1, 4'h0, 32'h3C);
        drain();

        // Reset during DATA bit 3 of 0xF0
        step(1'b1, 1'b1, 4'h8, 32'd4);
        step(1'b1, 1'b1, 4'h0, 32'hF0);
        idle(1);
        s = (m_frames.size() != 0) ? m_frames[0].start : cyc;
        for (int i = 0; i < 40 && cyc < s + 17; i++) idle(1);
        do_reset(1);
        idle(50);
        step(1'b1, 1'b0, 4'h4, 32'h0);
        chk("post_rst_status", bus.uart_rdata, 32'h2);
        step(1'b1, 1'b1, 4'h8, 32'd3);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r  = $urandom_range(0, 99);
            wd = $urandom;
            lo = 2'($urandom);
            if (r < 60) begin
                idle(1);
            end else if (r < 68) begin
                step(1'b1, 1'b1, {2'd0, lo}, wd);
            end else if (r < 85) begin
                step(1'b1, 1'b0, {2'($urandom_range(0, 3)), lo}, wd);
            end else if (r < 90) begin
                step(1'b1, 1'b1, {2'd2, lo}, {wd[31:16], 16'($urandom_range(0, 5))});
            end else if (r < 95) begin
                step(1'b1, 1'b1, {2'd1, lo}, wd);
            end else if (r < 99) begin
                step(1'b1, 1'b1, {2'd3, lo}, wd);
            end else begin
                do_reset(1 + $urandom_range(0, 2));
                step(1'b1, 1'b1, 4'h8, 32'($urandom_range(2, 5)));
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
